// File: rtl/sine_voice_scheduler.sv
// Shares one registered quarter-wave sine ROM among VOICES phase-accumulator oscillators, one voice per cycle.
// Optional hard sync on increment writes: define SINE_SCHED_SYNC_EN.
module sine_voice_scheduler #(
  parameter int N       = 7,
  parameter int VOICES  = 4,
  parameter int VIDX_W  = 2,
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [VIDX_W-1:0]  cfg_voice,
  input  logic [PHASE_W-1:0] cfg_inc,
  output logic               cfg_ready,
  output logic [N:0]         rom_addr,
  input  logic [N-1:0]       rom_data,
  output logic [N:0]         sample,
  output logic [VIDX_W-1:0]  sample_voice,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [N:0]        ADDR_FULL  = {1'b1, {N{1'b0}}};
  localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(VOICES - 1);

  state_t              state, state_nxt;
  logic [VIDX_W-1:0]   issue_idx;
  logic                issue;
  logic                issue_last;
  logic                cfg_ok;

  logic [PHASE_W-1:0]  phase [VOICES];
  logic [PHASE_W-1:0]  inc   [VOICES];

  logic [1:0]          quad;
  logic [N-1:0]        quad_addr;
  logic [N:0]          addr_fold;

  logic                valid_q;
  logic                neg_q;
  logic [VIDX_W-1:0]   voice_q;
  logic [N:0]          sample_new;
  logic [N:0]          sample_hold;
  logic                overrun_q;

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: defaulting next-state first keeps this block free of inferred latches.
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick)       state_nxt = S_RUN;
      S_RUN:   if (issue_last) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign issue      = (state == S_RUN);
  assign issue_last = issue && (issue_idx == LAST_VOICE);
  assign busy       = (state != S_IDLE);
  assign cfg_ready  = (state == S_IDLE) && !tick;
  assign cfg_ok     = cfg_we && cfg_ready && (int'(cfg_voice) < VOICES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_idx <= '0;
    end else if (issue) begin
      issue_idx <= issue_last ? '0 : issue_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------- voice state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these small register arrays are reset explicitly; a true RAM would not be, but voices must restart silent.
      for (int v = 0; v < VOICES; v++) begin
        phase[v] <= '0;
        inc[v]   <= '0;
      end
    end else begin
      if (issue) begin
        phase[issue_idx] <= phase[issue_idx] + inc[issue_idx];
      end
      if (cfg_ok) begin
        inc[cfg_voice] <= cfg_inc;
`ifdef SINE_SCHED_SYNC_EN
        phase[cfg_voice] <= '0;
`endif
      end
    end
  end

  // Quadrant folding: odd quadrants read the table backwards, address 2^N is full scale.
  assign quad      = phase[issue_idx][PHASE_W-1 -: 2];
  assign quad_addr = phase[issue_idx][PHASE_W-3 -: N];
  assign addr_fold = quad[0] ? (ADDR_FULL - {1'b0, quad_addr}) : {1'b0, quad_addr};
  assign rom_addr  = issue ? addr_fold : '0;

  // ---------------------------------------------------------------- output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      neg_q   <= 1'b0;
      voice_q <= '0;
    end else begin
      valid_q <= issue;
      if (issue) begin
        neg_q   <= quad[1];
        voice_q <= issue_idx;
      end
    end
  end

  // Negative half mirrors around midscale: {0, all-ones - d} is {0, ~d}.
  assign sample_new = neg_q ? {1'b0, ~rom_data} : {1'b1, rom_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_hold <= '0;
    end else if (valid_q) begin
      sample_hold <= sample_new;
    end
  end

  assign sample       = valid_q ? sample_new : sample_hold;
  assign sample_valid = valid_q;
  assign sample_voice = voice_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= tick && busy;
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Directed bench for sine_voice_scheduler with a registered quarter-sine ROM model (rom[0]=0, rom[128]=127).
module tb_sine_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        cfg_we;
  logic [1:0]  cfg_voice;
  logic [15:0] cfg_inc;
  logic        cfg_ready;
  logic [7:0]  rom_addr;
  logic [6:0]  rom_data;
  logic [7:0]  sample;
  logic [1:0]  sample_voice;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [6:0] rom [129];

  sine_voice_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_inc      (cfg_inc),
    .cfg_ready    (cfg_ready),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_voice (sample_voice),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i <= 128; i++)
      rom[i] = 7'($rtoi(127.0 * $sin(3.141592653589793 * real'(i) / 256.0) + 0.5));
  end

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [15:0] value);
    cfg_we    = 1'b1;
    cfg_voice = v;
    cfg_inc   = value;
    check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    step();
    cfg_we    = 1'b0;
  endtask

  // Runs one frame from IDLE; exp[v] is the sample expected for voice v.
  task automatic do_frame(input string tag, input logic [3:0][7:0] exp, input logic [7:0] addr0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check({tag, "_busy_t1"}, 32'(busy), 32'd1);
    check({tag, "_novalid_t1"}, 32'(sample_valid), 32'd0);
    check({tag, "_addr0"}, 32'(rom_addr), 32'(addr0));
    for (int v = 0; v < 4; v++) begin
      step();
      check({tag, "_valid"}, 32'(sample_valid), 32'd1);
      check({tag, "_voice"}, 32'(sample_voice), 32'(v));
      check({tag, "_sample"}, 32'(sample), 32'(exp[v]));
      check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    step();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_endvalid"}, 32'(sample_valid), 32'd0);
    check({tag, "_hold"}, 32'(sample), 32'(exp[3]));
  endtask

  int nvalid;
  int nover;

  initial begin
    rst       = 1'b1;
    tick      = 1'b0;
    cfg_we    = 1'b0;
    cfg_voice = '0;
    cfg_inc   = '0;
    #1;
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_voice", 32'(sample_voice), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // 1: all increments zero -> midscale on every voice
    do_frame("t1", {8'h80, 8'h80, 8'h80, 8'h80}, 8'd0);

    // 2: voice 0 steps a quarter turn per frame
    cfg_write(2'd0, 16'h4000);
    do_frame("t2a", {8'h80, 8'h80, 8'h80, 8'h80}, 8'd0);
    do_frame("t2b", {8'h80, 8'h80, 8'h80, 8'hFF}, 8'd128);
    do_frame("t2c", {8'h80, 8'h80, 8'h80, 8'h7F}, 8'd0);
    do_frame("t2d", {8'h80, 8'h80, 8'h80, 8'h00}, 8'd128);

    // 3: second tick two cycles later is lost and flagged
    tick = 1'b1;
    step();
    tick = 1'b0;
    nvalid = 0;
    nover  = 0;
    for (int i = 1; i <= 12; i++) begin
      if (sample_valid) nvalid++;
      if (overrun) nover++;
      if (i == 3) check("t3_overrun_pulse", 32'(overrun), 32'd1);
      tick = (i == 2);
      step();
    end
    tick = 1'b0;
    check("t3_sample_count", 32'(nvalid), 32'd4);
    check("t3_overrun_count", 32'(nover), 32'd1);
    check("t3_idle", 32'(busy), 32'd0);

    // 4: writes with tick or while busy are refused
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    tick      = 1'b1;
    cfg_we    = 1'b1;
    cfg_voice = 2'd0;
    cfg_inc   = 16'h4000;
    #1;
    check("t4_ready_with_tick", 32'(cfg_ready), 32'd0);
    step();
    tick = 1'b0;
    check("t4_ready_busy", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_ready_busy", 32'(cfg_ready), 32'd0);
    end
    cfg_we = 1'b0;
    step();
    do_frame("t4a", {8'h80, 8'h80, 8'h80, 8'h80}, 8'd0);
    do_frame("t4b", {8'h80, 8'h80, 8'h80, 8'h80}, 8'd0);

    // 5: reset in the middle of a frame
    cfg_write(2'd0, 16'h4000);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    check("t5_mid_voice", 32'(sample_voice), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_sample", 32'(sample), 32'd0);
    check("t5_rst_valid", 32'(sample_valid), 32'd0);
    check("t5_rst_voice", 32'(sample_voice), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    do_frame("t5_restart", {8'h80, 8'h80, 8'h80, 8'h80}, 8'd0);

    // 6: phase 0xFF00 plus 0x0200 wraps silently into quadrant 0
    cfg_write(2'd0, 16'hFF00);
    do_frame("t6a", {8'h80, 8'h80, 8'h80, 8'h80}, 8'd0);
    cfg_write(2'd0, 16'h0200);
`ifdef SINE_SCHED_SYNC_EN
    do_frame("t6_sync", {8'h80, 8'h80, 8'h80, 8'h80}, 8'd0);
    do_frame("t6_after", {8'h80, 8'h80, 8'h80, 8'h86}, 8'd4);
`else
    do_frame("t6_q3", {8'h80, 8'h80, 8'h80, 8'h7C}, 8'd2);
    do_frame("t6_wrap", {8'h80, 8'h80, 8'h80, 8'h83}, 8'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
